hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. It sits beside the decode stage and tracks the destination registers of the three older in-flight instructions (EX, MEM, WB) in an internal scoreboard. From that it produces stall, flush and operand-forwarding controls for the fetch/decode pipeline registers. It also sequences the redirect bubble after taken branches and jumps resolved in decode.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forwarding control for the five-stage RV32I core.
// Tracks destination registers of the EX, MEM and WB instructions and sequences
// the IF/ID flush after a redirect resolved in decode.
// Optional feature macro: HAZARD_FWD_EN (defined = operand forwarding enabled;
// undefined = no forwarding, every register dependency stalls until retired).
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_load,
  input  logic       id_redirect,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef enum logic {RUN, FLUSH} state_t;

  // Remaining FLUSH-state cycles after the redirect cycle itself, minus one.
  localparam logic [1:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;

  // Scoreboard: valid here already means "valid and writes rd".
  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_ld;

  logic src_ex, src_mem, src_wb;
  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic ld_stall, stall;
  logic [1:0] fa, fb;

  assign src_ex  = ex_v  && (ex_rd  != '0);
  assign src_mem = mem_v && (mem_rd != '0);
  assign src_wb  = wb_v  && (wb_rd  != '0);

  assign a_ex  = id_use_rs1 && src_ex  && (ex_rd  == id_rs1);
  assign a_mem = id_use_rs1 && src_mem && (mem_rd == id_rs1);
  assign a_wb  = id_use_rs1 && src_wb  && (wb_rd  == id_rs1);
  assign b_ex  = id_use_rs2 && src_ex  && (ex_rd  == id_rs2);
  assign b_mem = id_use_rs2 && src_mem && (mem_rd == id_rs2);
  assign b_wb  = id_use_rs2 && src_wb  && (wb_rd  == id_rs2);

  assign ld_stall = (a_ex || b_ex) && ex_ld;

  // Stall condition and forwarding selects (youngest matching entry wins).
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
`ifdef HAZARD_FWD_EN
    stall = ld_stall;
    if (a_ex && !ex_ld) fa = 2'b01;
    else if (a_mem)     fa = 2'b10;
    else if (a_wb)      fa = 2'b11;
    if (b_ex && !ex_ld) fb = 2'b01;
    else if (b_mem)     fb = 2'b10;
    else if (b_wb)      fb = 2'b11;
`else
    // Without forwarding any match stalls; the load term is a subset of it.
    stall = ld_stall || a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
`endif
  end

  // Pipeline control outputs and FSM next state.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    state_nx    = state;
    cnt_nx      = cnt;
    if (!rst) begin
      fwd_a = fa;
      fwd_b = fb;
      case (state)
        RUN: begin
          if (stall) begin
            // Redirect is ignored here; decode re-resolves it next cycle.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_redirect) begin
            ifid_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nx = FLUSH;
              cnt_nx   = CNT_INIT;
            end
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - 2'd1;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // State register and scoreboard shift EX -> MEM -> WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_rd  <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
      ex_ld  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= id_valid && !idex_bubble && id_reg_write;
      ex_rd  <= id_rd;
      ex_ld  <= id_load;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random decode
// traffic, compared every cycle against a list-based model of in-flight writers.
module tb_hazard_ctrl;

  localparam int FC = 3;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_load, id_redirect;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_load(id_load),
    .id_redirect(id_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  // Model: list of the three older instructions that are real register writers.
  typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
  ent_t hist[3];
  int   flush_left = 0;

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
    forever begin
      int ha, hb, e_fa, e_fb;
      bit stl, e_pc, e_ife, e_fl, e_bub, chk_fwd, bad;
      ent_t ne;
      @(negedge clk);
      cyc++;
      ha = -1; hb = -1;
      for (int i = 0; i < 3; i++) begin
        if (ha < 0 && id_use_rs1 && hist[i].v && hist[i].rd == id_rs1) ha = i;
        if (hb < 0 && id_use_rs2 && hist[i].v && hist[i].rd == id_rs2) hb = i;
      end
      if (FWD) begin
        stl  = (ha == 0 || hb == 0) && hist[0].ld;
        e_fa = ha + 1;
        e_fb = hb + 1;
      end else begin
        stl  = (ha >= 0) || (hb >= 0);
        e_fa = 0;
        e_fb = 0;
      end
      e_pc = 1; e_ife = 1; e_fl = 0; e_bub = 0; chk_fwd = 1;
      if (rst) begin
        stl = 0; e_fa = 0; e_fb = 0;
      end else if (flush_left > 0) begin
        stl = 0; e_fl = 1; e_bub = 1;
      end else if (stl) begin
        e_pc = 0; e_ife = 0; e_bub = 1; chk_fwd = 0;
      end else if (id_redirect) begin
        e_fl = 1;
      end
      n_vec++;
      bad = 0;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== {e_pc, e_ife, e_fl, e_bub}) begin
        bad = 1;
        $display("FAIL cycle %0d ctrl{pc_en,ifid_en,ifid_flush,idex_bubble} got %b want %b",
                 cyc, {pc_en, ifid_en, ifid_flush, idex_bubble}, {e_pc, e_ife, e_fl, e_bub});
      end
      if (chk_fwd && ({fwd_a, fwd_b} !== {2'(e_fa), 2'(e_fb)})) begin
        bad = 1;
        $display("FAIL cycle %0d fwd{a,b} got %b_%b want %b_%b",
                 cyc, fwd_a, fwd_b, 2'(e_fa), 2'(e_fb));
      end
      if (bad) n_bad++;
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        flush_left = 0;
      end else begin
        ne.v  = id_valid && !e_bub && id_reg_write && (id_rd != 0);
        ne.rd = id_rd;
        ne.ld = id_load;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = ne;
        if (flush_left > 0) flush_left--;
        else if (id_redirect && !stl) flush_left = FC - 1;
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic put(input bit r, input bit v, input bit [4:0] rs1, input bit u1,
                     input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                     input bit wr, input bit ld, input bit redir);
    rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
    id_use_rs2 = u2; id_rd = rd; id_reg_write = wr; id_load = ld; id_redirect = redir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stall_count(output int n);
    n = 0;
    while (pc_en !== 1'b1 && n < 8) begin
      n++;
      tick();
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    put(1, 1, 5, 1, 5, 1, 5, 1, 1, 1);
    lit("rst_pc_en", pc_en, 1);
    lit("rst_ifid_en", ifid_en, 1);
    lit("rst_flush", ifid_flush, 0);
    lit("rst_bubble", idex_bubble, 0);
    lit("rst_fwd", {fwd_a, fwd_b}, 0);
    tick();
    put(1, 1, 5, 1, 5, 1, 5, 1, 1, 1);
    lit("rst2_pc_en", pc_en, 1);
    tick();
    put(0, 1, 5, 1, 0, 0, 9, 0, 0, 0);
    lit("post_rst_x5_pc_en", pc_en, 1);
    lit("post_rst_x5_fwd", fwd_a, 0);
    tick();
    idle(3);

    // add x5,x1,x2 ; sub x6,x5,x3 ; two more readers of x5
    put(0, 1, 1, 1, 2, 1, 5, 1, 0, 0);
    tick();
    put(0, 1, 5, 1, 3, 1, 6, 1, 0, 0);
    stall_count(n);
    lit("alu_stalls", n, FWD ? 0 : 3);
    lit("alu_fwd_a_ex", fwd_a, FWD ? 1 : 0);
    tick();
    put(0, 1, 5, 1, 0, 0, 7, 1, 0, 0);
    lit("alu_fwd_a_mem", fwd_a, FWD ? 2 : 0);
    tick();
    put(0, 1, 0, 0, 5, 1, 8, 1, 0, 0);
    lit("alu_fwd_b_wb", fwd_b, FWD ? 3 : 0);
    tick();
    idle(3);

    // lw x7 ; add x8,x7,x7
    put(0, 1, 1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    put(0, 1, 7, 1, 7, 1, 8, 1, 0, 0);
    lit("lu_bubble", idex_bubble, 1);
    lit("lu_ifid_en", ifid_en, 0);
    stall_count(n);
    lit("lu_stalls", n, FWD ? 1 : 3);
    lit("lu_fwd", {fwd_a, fwd_b}, FWD ? 4'b1010 : 4'b0000);
    tick();
    idle(3);

    // lw x0 ; reader of x0
    put(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    tick();
    put(0, 1, 0, 1, 0, 1, 8, 1, 0, 0);
    stall_count(n);
    lit("x0_stalls", n, 0);
    lit("x0_fwd", {fwd_a, fwd_b}, 0);
    tick();
    idle(3);

    // Redirect: three flush cycles, second redirect ignored
    put(0, 1, 1, 1, 2, 1, 10, 1, 0, 1);
    lit("rd0_flush", ifid_flush, 1);
    lit("rd0_bubble", idex_bubble, 0);
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lit("rd1_flush", ifid_flush, 1);
    lit("rd1_bubble", idex_bubble, 1);
    tick();
    lit("rd2_flush", ifid_flush, 1);
    lit("rd2_bubble", idex_bubble, 1);
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rd3_flush", ifid_flush, 0);
    lit("rd3_bubble", idex_bubble, 0);
    tick();
    idle(3);

    // Redirect coinciding with load-use stall is deferred
    put(0, 1, 1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    put(0, 1, 7, 1, 0, 0, 8, 1, 0, 1);
    lit("rdlu_flush_held", ifid_flush, 0);
    stall_count(n);
    lit("rdlu_stalls", n, FWD ? 1 : 3);
    lit("rdlu_flush", ifid_flush, 1);
    tick();
    idle(5);

    // Reset in the second flush cycle
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rstfl_flush", ifid_flush, 0);
    lit("rstfl_bubble", idex_bubble, 0);
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rstfl_after_flush", ifid_flush, 0);
    lit("rstfl_after_bubble", idex_bubble, 0);
    tick();

    // Random decode traffic with a small register window to provoke hazards
    for (int k = 0; k < 600; k++) begin
      bit r, v, u1, u2, busy;
      r    = ($urandom_range(0, 39) == 0);
      busy = (flush_left > 0);
      v    = !busy && ($urandom_range(0, 99) < 85);
      u1   = v && $urandom_range(0, 1) == 1;
      u2   = v && $urandom_range(0, 1) == 1;
      put(r, v, 5'($urandom_range(0, 3)), u1, 5'($urandom_range(0, 3)), u2,
          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15);
      tick();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
